// File: rtl/risc_pkg.sv
// Shared definitions for the writeback path of the core.
//   DATA_W     : register-file write data width
//   ADDR_W     : register-file address width
//   REG_ZERO   : architectural zero register index (writes to it are dropped)
//   wb_state_t : occupancy of the registered writeback output stage
package risc_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int REG_ZERO = 0;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } wb_state_t;

endpackage : risc_pkg

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter with a single last-grant flop.
//   clk     : rising-edge clock
//   rst     : asynchronous, active-high reset (last grant resets to 1 so
//             requester 0 wins the first tie)
//   valid   : request valid per requester
//   advance : a grant was consumed this cycle; remember it as last grant
//   grant   : combinational winner (0 or 1)
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  input  logic       advance,
  output logic       grant
);

  logic last_grant_q;
  logic last_grant_d;

  // With no request the grant parks on the previous winner, so the data
  // mux does not toggle needlessly; on a tie the other requester wins.
  // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    grant = last_grant_q;
    unique case (valid)
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      2'b11:   grant = ~last_grant_q;
      default: grant = last_grant_q;
    endcase
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (advance) last_grant_d = grant;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_grant_q <= 1'b1;
    else     last_grant_q <= last_grant_d;
  end

endmodule : rr_arb2

// File: rtl/selector_2x1.sv
// Two-input data selector shared by the writeback path.
//   d0_i  : data presented when sel_i = 0
//   d1_i  : data presented when sel_i = 1
//   sel_i : select
//   y_o   : selected data
module selector_2x1 #(
  parameter int W = 32
) (
  input  logic [W-1:0] d0_i,
  input  logic [W-1:0] d1_i,
  input  logic         sel_i,
  output logic [W-1:0] y_o
);

  assign y_o = sel_i ? d1_i : d0_i;

endmodule : selector_2x1

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between the ALU result (requester 0)
// and load data (requester 1). Round-robin grant, one registered output
// stage with valid/ready handshake, per-requester saturating grant counters.
//   clk, rst          : clock, asynchronous active-high reset
//   req_valid/ready   : per-requester handshake, bit i = requester i
//   req0_data/addr    : ALU writeback
//   req1_data/addr    : load writeback
//   mux_sel           : combinational grant, drives the data selector
//   wb_valid/ready    : registered write request to the register file
//   wb_data/addr      : registered write payload
//   cnt_clear         : synchronous clear of both grant counters
//   grant_cnt0/1      : saturating accepted-transfer counts
module wb_port_arbiter #(
  parameter int DATA_W         = risc_pkg::DATA_W,
  parameter int ADDR_W         = risc_pkg::ADDR_W,
  parameter int CNT_W          = 16,
  parameter bit DROP_ZERO_ADDR = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [DATA_W-1:0] req0_data,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req1_data,
  input  logic [ADDR_W-1:0] req1_addr,
  output logic              mux_sel,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [DATA_W-1:0] wb_data,
  output logic [ADDR_W-1:0] wb_addr,
  input  logic              cnt_clear,
  output logic [CNT_W-1:0]  grant_cnt0,
  output logic [CNT_W-1:0]  grant_cnt1
);

  import risc_pkg::wb_state_t;
  import risc_pkg::EMPTY;
  import risc_pkg::FULL;
  import risc_pkg::REG_ZERO;

  wb_state_t         state_q, state_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic [ADDR_W-1:0] wb_addr_q, wb_addr_d;
  logic [CNT_W-1:0]  cnt0_q, cnt0_d;
  logic [CNT_W-1:0]  cnt1_q, cnt1_d;

  logic              grant;
  logic              load_en;
  logic              accept;
  logic              drop;
  logic              load;
  logic [DATA_W-1:0] sel_data;
  logic [ADDR_W-1:0] sel_addr;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .valid   (req_valid),
    .advance (accept),
    .grant   (grant)
  );

  selector_2x1 #(.W(DATA_W)) u_data_sel (
    .d0_i  (req0_data),
    .d1_i  (req1_data),
    .sel_i (grant),
    .y_o   (sel_data)
  );

  assign sel_addr = grant ? req1_addr : req0_addr;
  assign mux_sel  = grant;

  // The stage can take a new entry when empty or when its entry leaves now.
  assign load_en   = (state_q == EMPTY) | wb_ready;
  assign req_ready = {load_en & req_valid[1] & grant,
                      load_en & req_valid[0] & ~grant};
  assign accept    = |req_ready;

  // A zero-register write is still handshaken and counted, it just never
  // reaches the register file.
  assign drop = DROP_ZERO_ADDR && (sel_addr == ADDR_W'(REG_ZERO));
  assign load = accept & ~drop;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY: if (load) state_d = FULL;
      FULL:  if (wb_ready && !load) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  // Payload only changes on a real load, so it stays stable while stalled
  // and keeps the last delivered value across a dropped write.
  always_comb begin
    wb_data_d = wb_data_q;
    wb_addr_d = wb_addr_q;
    if (load) begin
      wb_data_d = sel_data;
      wb_addr_d = sel_addr;
    end
  end

  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (cnt_clear) begin
      cnt0_d = '0;
      cnt1_d = '0;
    end else if (accept) begin
      if (!grant && cnt0_q != '1) cnt0_d = cnt0_q + CNT_W'(1);
      if ( grant && cnt1_q != '1) cnt1_d = cnt1_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= EMPTY;
      wb_data_q <= '0;
      wb_addr_q <= '0;
      cnt0_q    <= '0;
      cnt1_q    <= '0;
    end else begin
      state_q   <= state_d;
      wb_data_q <= wb_data_d;
      wb_addr_q <= wb_addr_d;
      cnt0_q    <= cnt0_d;
      cnt1_q    <= cnt1_d;
    end
  end

  assign wb_valid   = (state_q == FULL);
  assign wb_data    = wb_data_q;
  assign wb_addr    = wb_addr_q;
  assign grant_cnt0 = cnt0_q;
  assign grant_cnt1 = cnt1_q;

endmodule : wb_port_arbiter

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [DATA_W-1:0] req0_data, req1_data;
  logic [ADDR_W-1:0] req0_addr, req1_addr;
  logic              mux_sel;
  logic              wb_valid;
  logic              wb_ready;
  logic [DATA_W-1:0] wb_data;
  logic [ADDR_W-1:0] wb_addr;
  logic              cnt_clear;
  logic [CNT_W-1:0]  grant_cnt0, grant_cnt1;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  wb_port_arbiter #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W), .DROP_ZERO_ADDR(1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req0_data  (req0_data),
    .req0_addr  (req0_addr),
    .req1_data  (req1_data),
    .req1_addr  (req1_addr),
    .mux_sel    (mux_sel),
    .wb_valid   (wb_valid),
    .wb_ready   (wb_ready),
    .wb_data    (wb_data),
    .wb_addr    (wb_addr),
    .cnt_clear  (cnt_clear),
    .grant_cnt0 (grant_cnt0),
    .grant_cnt1 (grant_cnt1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic        exp_g;
    logic [31:0] exp_d;

    // 1. reset with both requesters valid
    rst = 1'b1; req_valid = 2'b11; wb_ready = 1'b1; cnt_clear = 1'b0;
    req0_data = 32'hA000_0000; req0_addr = 5'd1;
    req1_data = 32'hB000_0000; req1_addr = 5'd2;
    #2;
    check("rst_wb_valid", 32'(wb_valid), 0);
    check("rst_wb_data",  32'(wb_data),  0);
    check("rst_wb_addr",  32'(wb_addr),  0);
    check("rst_cnt0",     32'(grant_cnt0), 0);
    check("rst_cnt1",     32'(grant_cnt1), 0);
    repeat (2) tick();
    check("rst_hold_wb_valid", 32'(wb_valid), 0);
    rst = 1'b0;
    #1;
    check("t1_mux_sel",   32'(mux_sel),   0);
    check("t1_req_ready", 32'(req_ready), 32'h1);
    tick();
    check("t1_wb_valid", 32'(wb_valid), 1);
    check("t1_wb_data",  32'(wb_data),  32'hA000_0000);
    check("t1_wb_addr",  32'(wb_addr),  1);
    check("t1_cnt0",     32'(grant_cnt0), 1);

    // 2. both valid continuously, strict alternation
    req_valid = 2'b00; cnt_clear = 1'b1;
    tick();
    cnt_clear = 1'b0;
    check("t2_pre_cnt0",     32'(grant_cnt0), 0);
    check("t2_pre_wb_valid", 32'(wb_valid),   0);
    req0_addr = 5'd3; req1_addr = 5'd4;
    for (int k = 0; k < 10; k++) begin
      req0_data = 32'hAAAA_0000 + k;
      req1_data = 32'h5555_0000 + k;
      req_valid = 2'b11;
      #1;
      // last grant is 0 after the step-1 accept, so requester 1 wins first
      exp_g = (k % 2 == 0);
      exp_d = exp_g ? 32'h5555_0000 + k : 32'hAAAA_0000 + k;
      check($sformatf("t2_mux_sel_%0d", k), 32'(mux_sel), 32'(exp_g));
      tick();
      check($sformatf("t2_wb_valid_%0d", k), 32'(wb_valid), 1);
      check($sformatf("t2_wb_data_%0d", k), wb_data, exp_d);
    end
    check("t2_cnt0", 32'(grant_cnt0), 5);
    check("t2_cnt1", 32'(grant_cnt1), 5);

    // 3. stall while full, then resume with no bubble
    wb_ready  = 1'b0;
    req0_data = 32'hAAAA_000A;
    req1_data = 32'h5555_000A;
    #1;
    check("t3_req_ready_stall", 32'(req_ready), 0);
    for (int s = 0; s < 3; s++) begin
      tick();
      check($sformatf("t3_wb_data_%0d", s),   wb_data, 32'hAAAA_0009);
      check($sformatf("t3_wb_addr_%0d", s),   32'(wb_addr), 3);
      check($sformatf("t3_req_ready_%0d", s), 32'(req_ready), 0);
    end
    check("t3_cnt1_held", 32'(grant_cnt1), 5);
    wb_ready = 1'b1;
    #1;
    check("t3_req_ready_go", 32'(req_ready), 32'h2);
    tick();
    check("t3_wb_valid", 32'(wb_valid), 1);
    check("t3_wb_data",  wb_data, 32'h5555_000A);
    check("t3_wb_addr",  32'(wb_addr), 4);
    check("t3_cnt1",     32'(grant_cnt1), 6);

    // 4. requester 1 writes register 0: handshaken and counted, never presented
    req_valid = 2'b10; req1_addr = 5'd0; req1_data = 32'hDEAD_0000;
    #1;
    check("t4_req_ready_a", 32'(req_ready), 32'h2);
    tick();
    check("t4_wb_valid_a", 32'(wb_valid), 0);
    check("t4_cnt1_a",     32'(grant_cnt1), 7);
    check("t4_wb_data_a",  wb_data, 32'h5555_000A);
    check("t4_req_ready_b", 32'(req_ready), 32'h2);
    tick();
    check("t4_wb_valid_b", 32'(wb_valid), 0);
    check("t4_cnt1_b",     32'(grant_cnt1), 8);

    // 5. saturation of the 4-bit counter, then clear coincident with accept
    req_valid = 2'b01; req0_addr = 5'd7;
    for (int i = 0; i < 20; i++) begin
      req0_data = 32'hC000_0000 + i;
      tick();
      if (i == 8) check("t5_cnt0_mid", 32'(grant_cnt0), 14);
    end
    check("t5_wb_valid", 32'(wb_valid), 1);
    check("t5_wb_data",  wb_data, 32'hC000_0013);
    check("t5_cnt0_sat", 32'(grant_cnt0), 15);
    check("t5_cnt1",     32'(grant_cnt1), 8);
    req0_data = 32'hC000_0100; cnt_clear = 1'b1;
    tick();
    cnt_clear = 1'b0;
    check("t5_clr_cnt0",    32'(grant_cnt0), 0);
    check("t5_clr_cnt1",    32'(grant_cnt1), 0);
    check("t5_clr_wb_data", wb_data, 32'hC000_0100);
    tick();
    check("t5_cnt0_after", 32'(grant_cnt0), 1);

    // 6. asynchronous reset while full with both valid
    req_valid = 2'b11; wb_ready = 1'b0;
    tick();
    check("t6_pre_wb_valid", 32'(wb_valid), 1);
    #2;
    rst = 1'b1;
    #1;
    check("t6_async_wb_valid", 32'(wb_valid), 0);
    check("t6_async_wb_data",  wb_data, 0);
    check("t6_async_cnt0",     32'(grant_cnt0), 0);
    tick();
    rst = 1'b0; wb_ready = 1'b1;
    #1;
    // last winner before reset was requester 0; reset restores the req0-first tie
    check("t6_mux_sel",   32'(mux_sel),   0);
    check("t6_req_ready", 32'(req_ready), 32'h1);
    tick();
    check("t6_wb_data", wb_data, 32'hC000_0100);
    check("t6_wb_addr", 32'(wb_addr), 7);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_wb_port_arbiter
